banked_register_file: RTL and testbench
=======================================

BANKED_REGISTER_FILE -- requirements
Module: banked_register_file

Interface
REQ-001 SHALL have parameter DataWidth, default 32, register width in bits.
REQ-002 SHALL have parameter RegNum, default 32, architectural registers per bank, power of two, >= 4.
REQ-003 SHALL have parameter NumBanks, default 4, banked contexts, power of two, >= 2.
REQ-004 SHALL have parameter MagicRa, default all-ones of DataWidth, value loaded into x1 (ra) on bank push.
REQ-005 SHALL have parameter BypassEn, default 1, enabling write-to-read forwarding.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: clk_i input 1 (rising edge), then rst_ni input 1.
REQ-007 SHALL have raddr_a_i input log2(RegNum) read port A address and rdata_a_o output DataWidth read port A data.
REQ-008 SHALL have raddr_b_i input log2(RegNum) read port B address and rdata_b_o output DataWidth read port B data.
REQ-009 SHALL have waddr_a_i input log2(RegNum), wdata_a_i input DataWidth and we_a_i input 1 as the write port.
REQ-010 SHALL have bank_push_i input 1, a one-cycle interrupt-entry strobe, and bank_pop_i input 1, a one-cycle interrupt-return strobe.
REQ-011 SHALL have bank_o output log2(NumBanks), the active bank index.
REQ-012 SHALL have init_busy_o output 1, high while the clear sweep runs.
REQ-013 SHALL have overflow_o output 1 and underflow_o output 1, sticky bank-stack error flags.

Function
REQ-014 x0 SHALL read 0 and ignore writes in every bank.
REQ-015 x2 (sp) SHALL be a single register shared by all banks; all other registers x1, x3..x(RegNum-1) SHALL be replicated per bank.
REQ-016 Reads SHALL be combinational from the active bank (bank_o) plus the shared sp.
REQ-017 A write SHALL take effect at the rising clk_i edge when we_a_i=1 and the FSM is READY, into the active bank at that edge.
REQ-018 With BypassEn=1, a read whose address equals waddr_a_i with we_a_i=1, READY and address!=0 SHALL return wdata_a_i in the same cycle; with BypassEn=0 it SHALL return the stored value.
REQ-019 FSM states SHALL be INIT and READY; INIT SHALL clear row idx in all banks and sp, one row per cycle, idx 0..RegNum-1, then go to READY; INIT therefore lasts exactly RegNum cycles.
REQ-020 During INIT, reads SHALL return 0, and writes, push and pop SHALL be ignored without setting error flags.
REQ-021 Push in READY with bank_o < NumBanks-1 SHALL increment bank_o at the edge and write MagicRa into x1 of the new bank at that same edge.
REQ-022 Pop in READY with bank_o > 0 SHALL decrement bank_o at the edge; register contents SHALL be kept.
REQ-023 Push at bank_o = NumBanks-1 SHALL set overflow_o and leave bank_o and all registers unchanged.
REQ-024 Pop at bank_o = 0 SHALL set underflow_o and leave bank_o unchanged.
REQ-025 Push and pop asserted together SHALL be a no-op: no bank change, no MagicRa load, no flag set.
REQ-026 A write in the same cycle as a push or pop SHALL land in the pre-switch bank; a write to x1 during a push SHALL update the old bank's x1, while the new bank's x1 receives MagicRa.
REQ-027 Once set, overflow_o and underflow_o SHALL clear only on reset.

Reset
REQ-028 Asserting rst_ni low SHALL immediately, asynchronously, set state=INIT, idx=0, bank_o=0, init_busy_o=1, overflow_o=0 and underflow_o=0.
REQ-029 While rst_ni is low, rdata_a_o and rdata_b_o SHALL read 0.
REQ-030 Reset asserted mid-sweep or mid-operation SHALL restart the sweep from idx 0 after release; no pre-reset register value SHALL be observable after INIT completes.
REQ-031 The storage array itself SHALL NOT be reset asynchronously; the sweep is the only clearing mechanism.

Verification
REQ-032 Release reset with RegNum=32 -> init_busy_o high for exactly 32 cycles; then every address in every bank reads 0.
REQ-033 Write x5=0x1234 in bank 0, push, read x5 -> 0, read x1 -> 0xFFFFFFFF; pop -> x5 reads 0x1234.
REQ-034 Write x2=0xABCD in bank 0, push twice -> x2 reads 0xABCD in bank 2.
REQ-035 With NumBanks=4, issue 4 pushes -> bank_o=3, overflow_o=1; pop at bank 0 -> underflow_o=1, bank_o stays 0.
REQ-036 Write x1=0x55 together with a push from bank 0 -> bank 1 x1 reads MagicRa; after pop, bank 0 x1 reads 0x55; same-cycle read of the write address returns 0x55 when BypassEn=1.
REQ-037 Assert rst_ni low at sweep idx 10, then release -> a full 32-cycle sweep is observed, with bank_o=0 and both flags cleared.

Source files
------------

// File: rtl/banked_register_file.sv
// Banked integer register file: one register set per interrupt level with a shared sp (x2),
// a power-on clear sweep, and push/pop bank switching with sticky overflow/underflow flags.
module banked_register_file #(
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          RegNum    = 32,
  parameter int unsigned          NumBanks  = 4,
  parameter logic [DataWidth-1:0] MagicRa   = '1,
  parameter bit                   BypassEn  = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [$clog2(RegNum)-1:0]    raddr_a_i,
  output logic [DataWidth-1:0]         rdata_a_o,
  input  logic [$clog2(RegNum)-1:0]    raddr_b_i,
  output logic [DataWidth-1:0]         rdata_b_o,
  input  logic [$clog2(RegNum)-1:0]    waddr_a_i,
  input  logic [DataWidth-1:0]         wdata_a_i,
  input  logic                         we_a_i,
  input  logic                         bank_push_i,
  input  logic                         bank_pop_i,
  output logic [$clog2(NumBanks)-1:0]  bank_o,
  output logic                         init_busy_o,
  output logic                         overflow_o,
  output logic                         underflow_o
);

  localparam int unsigned AW = $clog2(RegNum);
  localparam int unsigned BW = $clog2(NumBanks);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                 r_state;
  state_e                 w_state_next;
  logic [AW-1:0]          r_idx;
  logic [BW-1:0]          r_bank;
  logic                   r_overflow;
  logic                   r_underflow;
  logic                   w_busy;
  logic                   w_ready;

  logic [DataWidth-1:0]   r_mem [NumBanks][RegNum];
  logic [DataWidth-1:0]   r_sp;

  logic                   w_last_idx;
  logic                   w_push_req;
  logic                   w_pop_req;
  logic                   w_at_top;
  logic                   w_at_bot;
  logic                   w_do_push;
  logic                   w_do_pop;
  logic [BW-1:0]          w_bank_up;
  logic                   w_wr_en;
  logic                   w_wr_sp;
  logic                   w_wr_bank;

  logic [DataWidth-1:0]   w_stored_a;
  logic [DataWidth-1:0]   w_stored_b;
  logic                   w_hit_a;
  logic                   w_hit_b;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_INIT) begin
        r_idx <= r_idx + AW'(1);
      end
    end
  end

  assign w_last_idx = (r_idx == AW'(RegNum - 1));

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_INIT:  if (w_last_idx) w_state_next = ST_READY;
      ST_READY: w_state_next = ST_READY;
      default:  w_state_next = ST_INIT;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_busy  = 1'b0;
    w_ready = 1'b0;
    case (r_state)
      ST_INIT:  w_busy  = 1'b1;
      ST_READY: w_ready = 1'b1;
      default:  w_busy  = 1'b1;
    endcase
  end

  // Simultaneous push and pop cancel out entirely.
  assign w_push_req = w_ready & bank_push_i & ~bank_pop_i;
  assign w_pop_req  = w_ready & bank_pop_i & ~bank_push_i;
  assign w_at_top   = (r_bank == BW'(NumBanks - 1));
  assign w_at_bot   = (r_bank == '0);
  assign w_do_push  = w_push_req & ~w_at_top;
  assign w_do_pop   = w_pop_req & ~w_at_bot;
  assign w_bank_up  = r_bank + BW'(1);

  assign w_wr_en   = w_ready & we_a_i & (waddr_a_i != '0);
  assign w_wr_sp   = w_wr_en & (waddr_a_i == AW'(2));
  assign w_wr_bank = w_wr_en & (waddr_a_i != AW'(2));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bank      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_bank <= w_bank_up;
      end else if (w_do_pop) begin
        r_bank <= r_bank - BW'(1);
      end
      if (w_push_req && w_at_top) r_overflow  <= 1'b1;
      if (w_pop_req && w_at_bot)  r_underflow <= 1'b1;
    end
  end

  // Storage has no reset; the INIT sweep is the only way it gets cleared.
  generate
    for (genvar gi = 0; gi < NumBanks; gi++) begin : g_bank
      always_ff @(posedge clk_i) begin
        if (w_busy) begin
          r_mem[gi][r_idx] <= '0;
        end else begin
          if (w_wr_bank && (r_bank == BW'(gi))) begin
            r_mem[gi][waddr_a_i] <= wdata_a_i;
          end
          // The old bank's write and the new bank's ra load never collide.
          if (w_do_push && (w_bank_up == BW'(gi))) begin
            r_mem[gi][1] <= MagicRa;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (w_busy) begin
      r_sp <= '0;
    end else if (w_wr_sp) begin
      r_sp <= wdata_a_i;
    end
  end

  assign w_stored_a = (raddr_a_i == AW'(2)) ? r_sp : r_mem[r_bank][raddr_a_i];
  assign w_stored_b = (raddr_b_i == AW'(2)) ? r_sp : r_mem[r_bank][raddr_b_i];
  assign w_hit_a    = BypassEn && w_wr_en && (raddr_a_i == waddr_a_i);
  assign w_hit_b    = BypassEn && w_wr_en && (raddr_b_i == waddr_a_i);

  always_comb begin
    rdata_a_o = '0;
    if (w_ready && (raddr_a_i != '0)) begin
      rdata_a_o = w_hit_a ? wdata_a_i : w_stored_a;
    end
  end

  always_comb begin
    rdata_b_o = '0;
    if (w_ready && (raddr_b_i != '0)) begin
      rdata_b_o = w_hit_b ? wdata_a_i : w_stored_b;
    end
  end

  assign bank_o      = r_bank;
  assign init_busy_o = w_busy;
  assign overflow_o  = r_overflow;
  assign underflow_o = r_underflow;

endmodule

// File: tb/tb_banked_register_file.sv
// Directed test of banked_register_file with default parameters (32-bit, 32 regs, 4 banks, bypass on).
module tb_banked_register_file;

  localparam int DW = 32;
  localparam int RN = 32;
  localparam int NB = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic [4:0]    raddr_a_i = '0;
  logic [DW-1:0] rdata_a_o;
  logic [4:0]    raddr_b_i = '0;
  logic [DW-1:0] rdata_b_o;
  logic [4:0]    waddr_a_i = '0;
  logic [DW-1:0] wdata_a_i = '0;
  logic          we_a_i = 1'b0;
  logic          bank_push_i = 1'b0;
  logic          bank_pop_i = 1'b0;
  logic [1:0]    bank_o;
  logic          init_busy_o;
  logic          overflow_o;
  logic          underflow_o;

  int checks = 0;
  int failures = 0;

  banked_register_file #(
    .DataWidth(DW), .RegNum(RN), .NumBanks(NB), .MagicRa('1), .BypassEn(1'b1)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .raddr_a_i(raddr_a_i), .rdata_a_o(rdata_a_o),
    .raddr_b_i(raddr_b_i), .rdata_b_o(rdata_b_o),
    .waddr_a_i(waddr_a_i), .wdata_a_i(wdata_a_i), .we_a_i(we_a_i),
    .bank_push_i(bank_push_i), .bank_pop_i(bank_pop_i),
    .bank_o(bank_o), .init_busy_o(init_busy_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    we_a_i = 1'b0; bank_push_i = 1'b0; bank_pop_i = 1'b0;
    waddr_a_i = '0; wdata_a_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic wait_init(output int cyc);
    cyc = 0;
    while (init_busy_o && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic reset_and_init();
    int c;
    do_reset();
    wait_init(c);
    checks++;
    if (c !== RN) begin
      failures++;
      $display("FAIL init_len actual=%0d expected=%0d", c, RN);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [DW-1:0] d);
    we_a_i = 1'b1; waddr_a_i = a; wdata_a_i = d;
    tick();
    we_a_i = 1'b0;
  endtask

  task automatic do_push();
    bank_push_i = 1'b1;
    tick();
    bank_push_i = 1'b0;
  endtask

  task automatic do_pop();
    bank_pop_i = 1'b1;
    tick();
    bank_pop_i = 1'b0;
  endtask

  task automatic test_reset();
    int c;
    logic [DW-1:0] exp_v;
    raddr_a_i = 5'd5;
    #3;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (init_busy_o !== 1'b1 || bank_o !== 2'd0 || overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_state actual=busy%b bank%0d ov%b un%b expected=busy1 bank0 ov0 un0",
               init_busy_o, bank_o, overflow_o, underflow_o);
    end
    checks++;
    if (rdata_a_o !== '0) begin
      failures++;
      $display("FAIL reset_rdata actual=%h expected=0", rdata_a_o);
    end
    tick();
    tick();
    rst_ni = 1'b1;
    wait_init(c);
    checks++;
    if (c !== RN) begin
      failures++;
      $display("FAIL sweep_len actual=%0d expected=%0d", c, RN);
    end
    $display("reset: sweep lasted %0d cycles", c);
    for (int b = 0; b < NB; b++) begin
      for (int a = 0; a < RN; a++) begin
        raddr_a_i = 5'(a);
        raddr_b_i = 5'(RN - 1 - a);
        #1;
        exp_v = (b > 0 && a == 1) ? '1 : '0;
        checks++;
        if (rdata_a_o !== exp_v) begin
          failures++;
          $display("FAIL clear_scan bank=%0d addr=%0d actual=%h expected=%h", b, a, rdata_a_o, exp_v);
        end
      end
      if (b < NB - 1) do_push();
    end
    $display("reset: scanned %0d banks", NB);
    for (int i = 0; i < NB - 1; i++) do_pop();
    checks++;
    if (bank_o !== 2'd0 || overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
      failures++;
      $display("FAIL scan_return actual=bank%0d ov%b un%b expected=bank0 ov0 un0", bank_o, overflow_o, underflow_o);
    end
  endtask

  task automatic test_init_ignore();
    do_reset();
    do_pop();
    raddr_a_i = 5'd1;
    #1;
    checks++;
    if (rdata_a_o !== '0 || init_busy_o !== 1'b1) begin
      failures++;
      $display("FAIL init_read actual=%h busy%b expected=0 busy1", rdata_a_o, init_busy_o);
    end
    // Advance to the last sweep cycle (idx 31), where a write to x5 would otherwise survive.
    for (int i = 0; i < RN - 2; i++) tick();
    we_a_i = 1'b1; waddr_a_i = 5'd5; wdata_a_i = 32'h0000_0BAD; bank_push_i = 1'b1;
    tick();
    clear_inputs();
    raddr_a_i = 5'd5;
    #1;
    checks++;
    if (init_busy_o !== 1'b0 || bank_o !== 2'd0 || overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
      failures++;
      $display("FAIL init_ignore_ctl actual=busy%b bank%0d ov%b un%b expected=busy0 bank0 ov0 un0",
               init_busy_o, bank_o, overflow_o, underflow_o);
    end
    checks++;
    if (rdata_a_o !== '0) begin
      failures++;
      $display("FAIL init_ignore_write actual=%h expected=0", rdata_a_o);
    end
    $display("init_ignore: bank=%0d x5=%h", bank_o, rdata_a_o);
  endtask

  task automatic test_bank_switch();
    reset_and_init();
    do_write(5'd5, 32'h1234);
    do_push();
    raddr_a_i = 5'd5; raddr_b_i = 5'd1;
    #1;
    checks++;
    if (bank_o !== 2'd1 || rdata_a_o !== 32'h0) begin
      failures++;
      $display("FAIL push_x5 actual=bank%0d %h expected=bank1 00000000", bank_o, rdata_a_o);
    end
    checks++;
    if (rdata_b_o !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL push_ra actual=%h expected=ffffffff", rdata_b_o);
    end
    do_pop();
    checks++;
    if (bank_o !== 2'd0 || rdata_a_o !== 32'h1234) begin
      failures++;
      $display("FAIL pop_x5 actual=bank%0d %h expected=bank0 00001234", bank_o, rdata_a_o);
    end
    $display("bank_switch: bank0 x5=%h", rdata_a_o);
  endtask

  task automatic test_shared_sp();
    reset_and_init();
    do_write(5'd2, 32'hABCD);
    do_push();
    do_push();
    raddr_a_i = 5'd2;
    #1;
    checks++;
    if (bank_o !== 2'd2 || rdata_a_o !== 32'hABCD) begin
      failures++;
      $display("FAIL shared_sp actual=bank%0d %h expected=bank2 0000abcd", bank_o, rdata_a_o);
    end
    $display("shared_sp: bank%0d sp=%h", bank_o, rdata_a_o);
  endtask

  task automatic test_overflow();
    reset_and_init();
    for (int i = 0; i < 3; i++) do_push();
    do_write(5'd1, 32'h7777);
    do_push();
    raddr_a_i = 5'd1;
    #1;
    checks++;
    if (bank_o !== 2'd3 || overflow_o !== 1'b1 || underflow_o !== 1'b0) begin
      failures++;
      $display("FAIL overflow actual=bank%0d ov%b un%b expected=bank3 ov1 un0", bank_o, overflow_o, underflow_o);
    end
    checks++;
    if (rdata_a_o !== 32'h7777) begin
      failures++;
      $display("FAIL overflow_keep actual=%h expected=00007777", rdata_a_o);
    end
    for (int i = 0; i < 3; i++) do_pop();
    checks++;
    if (bank_o !== 2'd0 || underflow_o !== 1'b0) begin
      failures++;
      $display("FAIL pop_down actual=bank%0d un%b expected=bank0 un0", bank_o, underflow_o);
    end
    do_pop();
    checks++;
    if (bank_o !== 2'd0 || underflow_o !== 1'b1 || overflow_o !== 1'b1) begin
      failures++;
      $display("FAIL underflow actual=bank%0d un%b ov%b expected=bank0 un1 ov1", bank_o, underflow_o, overflow_o);
    end
    do_push();
    checks++;
    if (bank_o !== 2'd1 || underflow_o !== 1'b1 || overflow_o !== 1'b1) begin
      failures++;
      $display("FAIL sticky actual=bank%0d un%b ov%b expected=bank1 un1 ov1", bank_o, underflow_o, overflow_o);
    end
    $display("overflow: flags ov=%b un=%b", overflow_o, underflow_o);
  endtask

  task automatic test_push_write();
    reset_and_init();
    we_a_i = 1'b1; waddr_a_i = 5'd1; wdata_a_i = 32'h55; bank_push_i = 1'b1;
    raddr_a_i = 5'd1;
    #1;
    checks++;
    if (rdata_a_o !== 32'h55) begin
      failures++;
      $display("FAIL bypass_ra actual=%h expected=00000055", rdata_a_o);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bank_o !== 2'd1 || rdata_a_o !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL push_write_new actual=bank%0d %h expected=bank1 ffffffff", bank_o, rdata_a_o);
    end
    do_pop();
    checks++;
    if (bank_o !== 2'd0 || rdata_a_o !== 32'h55) begin
      failures++;
      $display("FAIL push_write_old actual=bank%0d %h expected=bank0 00000055", bank_o, rdata_a_o);
    end
    $display("push_write: bank0 x1=%h", rdata_a_o);
  endtask

  task automatic test_push_pop_same();
    reset_and_init();
    bank_push_i = 1'b1; bank_pop_i = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (bank_o !== 2'd0 || overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
      failures++;
      $display("FAIL pushpop_b0 actual=bank%0d ov%b un%b expected=bank0 ov0 un0", bank_o, overflow_o, underflow_o);
    end
    do_push();
    do_write(5'd1, 32'h0000_00A1);
    bank_push_i = 1'b1; bank_pop_i = 1'b1;
    tick();
    clear_inputs();
    raddr_a_i = 5'd1;
    #1;
    checks++;
    if (bank_o !== 2'd1 || rdata_a_o !== 32'hA1) begin
      failures++;
      $display("FAIL pushpop_b1 actual=bank%0d %h expected=bank1 000000a1", bank_o, rdata_a_o);
    end
    $display("push_pop_same: bank=%0d", bank_o);
  endtask

  task automatic test_x0();
    we_a_i = 1'b1; waddr_a_i = 5'd0; wdata_a_i = 32'hDEAD; raddr_a_i = 5'd0;
    #1;
    checks++;
    if (rdata_a_o !== '0) begin
      failures++;
      $display("FAIL x0_bypass actual=%h expected=0", rdata_a_o);
    end
    tick();
    clear_inputs();
    checks++;
    if (rdata_a_o !== '0) begin
      failures++;
      $display("FAIL x0_write actual=%h expected=0", rdata_a_o);
    end
    $display("x0: reads %h", rdata_a_o);
  endtask

  task automatic test_back_to_back();
    reset_and_init();
    we_a_i = 1'b1;
    waddr_a_i = 5'd3; wdata_a_i = 32'h11; tick();
    waddr_a_i = 5'd4; wdata_a_i = 32'h22; tick();
    waddr_a_i = 5'd31; wdata_a_i = 32'h33; raddr_b_i = 5'd31;
    #1;
    checks++;
    if (rdata_b_o !== 32'h33) begin
      failures++;
      $display("FAIL b2b_bypass_b actual=%h expected=00000033", rdata_b_o);
    end
    tick();
    clear_inputs();
    raddr_a_i = 5'd3; raddr_b_i = 5'd4;
    #1;
    checks++;
    if (rdata_a_o !== 32'h11 || rdata_b_o !== 32'h22) begin
      failures++;
      $display("FAIL b2b_read actual=%h %h expected=00000011 00000022", rdata_a_o, rdata_b_o);
    end
    raddr_a_i = 5'd31;
    #1;
    checks++;
    if (rdata_a_o !== 32'h33) begin
      failures++;
      $display("FAIL b2b_x31 actual=%h expected=00000033", rdata_a_o);
    end
    $display("back_to_back: x3=11 x4=22 x31=33 written");
  endtask

  task automatic test_reset_mid();
    int c;
    reset_and_init();
    do_write(5'd5, 32'hBEEF);
    for (int i = 0; i < NB; i++) do_push();
    raddr_a_i = 5'd5;
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (bank_o !== 2'd0 || overflow_o !== 1'b0 || init_busy_o !== 1'b1 || rdata_a_o !== '0) begin
      failures++;
      $display("FAIL async_reset actual=bank%0d ov%b busy%b %h expected=bank0 ov0 busy1 0",
               bank_o, overflow_o, init_busy_o, rdata_a_o);
    end
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rst_ni = 1'b0;
    #1;
    checks++;
    if (init_busy_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_sweep_busy actual=%b expected=1", init_busy_o);
    end
    tick();
    rst_ni = 1'b1;
    wait_init(c);
    checks++;
    if (c !== RN) begin
      failures++;
      $display("FAIL resweep_len actual=%0d expected=%0d", c, RN);
    end
    checks++;
    if (bank_o !== 2'd0 || overflow_o !== 1'b0 || underflow_o !== 1'b0 || rdata_a_o !== '0) begin
      failures++;
      $display("FAIL resweep_state actual=bank%0d ov%b un%b x5=%h expected=bank0 ov0 un0 0",
               bank_o, overflow_o, underflow_o, rdata_a_o);
    end
    $display("reset_mid: resweep %0d cycles, x5=%h", c, rdata_a_o);
  endtask

  initial begin
    test_reset();
    test_init_ignore();
    test_bank_switch();
    test_shared_sp();
    test_overflow();
    test_push_write();
    test_push_pop_same();
    test_x0();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
